pipelined_universal_shifter: RTL
================================

Name: pipelined_universal_shifter

Overview:
- Parametrised, pipelined successor to the 16-bit combinational left/right barrel shifter.
- Supports five shift modes: logical left, logical right, arithmetic right, rotate left and rotate right.
- Operand width is configurable; the datapath is registered at every log2 mux level.
- Sits between an operand source and the ALU result bus, with valid/ready flow control on both sides.

Parameters:
- WIDTH, 16: operand width in bits; power of two, at least 4.
- SHW, $clog2(WIDTH)+1: shift-amount width (derived localparam, not overridable). For WIDTH=16 it is 5, matching the existing shifter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  an operand is presented.
- in_ready  output  1  the block can accept an operand this cycle.
- in_data  input  WIDTH  operand.
- in_shift  input  SHW  shift amount, unsigned.
- in_mode  input  3  000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR; 101–111 are illegal.
- out_valid  output  1  a result is present.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  shifted result.
- out_zero  output  1  out_data == 0.
- out_illegal  output  1  the operand was issued with an illegal mode.

Behaviour:
- Reset:
  - rst is sampled at a clock edge; on that edge all stage valids clear and out_data, out_zero and out_illegal go to 0.
  - in_ready is 1 in the cycle after reset.
  - rst asserted mid-operation discards every in-flight operand; no result is emitted for them.
- Pipeline:
  - There is an input register stage followed by $clog2(WIDTH) registered shift stages.
  - Stage k conditionally shifts by 2^k according to bit k of the effective amount.
  - Latency LAT = $clog2(WIDTH)+1 cycles from the accepting edge to out_valid=1 (5 for WIDTH=16).
  - Throughput is one operand per cycle when out_ready is held high.
- Handshake:
  - A transfer occurs when valid and ready are both 1 at a rising edge.
  - in_ready = !out_valid || out_ready (combinational path from out_ready is permitted).
  - The stall is global: when out_valid && !out_ready, every stage holds.
  - While stalled, out_data, out_zero and out_illegal stay stable.
  - Bubbles are not collapsed. Order is preserved; no loss, no duplication.
- Amount rules:
  - LSL / LSR: in_shift >= WIDTH gives all zeros.
  - ASR: in_shift >= WIDTH gives every bit equal to in_data[WIDTH-1].
  - ROL / ROR: the effective amount is in_shift mod WIDTH (low $clog2(WIDTH) bits).
  - in_shift = 0 gives out_data = in_data in every mode.
- Illegal mode: out_data = in_data (pass-through) and out_illegal = 1. Legal modes give out_illegal = 0.
- Mode, sign bit and the saturation condition (amount >= WIDTH) are captured in the input stage and travel with the data. Later inputs never affect in-flight operands.
- out_zero is computed from the final stage value and registered together with out_data.
- An input may be accepted in the same cycle an output is consumed; a full pipeline with out_ready=1 still accepts.

Test Plan (WIDTH=16, LAT=5):
- Reset and latency: hold rst 2 cycles → out_valid=0, out_data=0x0000, in_ready=1. Then issue LSL 0xFFFF by 15 with out_ready=1 → 0x8000 exactly 5 cycles later. Then LSR 0xFFFF by 15 → 0x0001.
- Arithmetic right and saturation:
  - ASR 0x8000 by 4 → 0xF800.
  - ASR 0x8000 by 20 → 0xFFFF.
  - ASR 0x4000 by 31 → 0x0000 with out_zero=1.
  - LSR 0xABCD by 16 → 0x0000 with out_zero=1.
- Rotates: ROL 0x1234 by 4 → 0x2341; ROR 0x1234 by 20 → 0x4123; ROL 0x8001 by 16 → 0x8001.
- Backpressure: stream 8 random legal operands back-to-back while out_ready toggles pseudo-randomly → results match the reference model in order with none dropped or repeated. in_ready=0 whenever out_valid=1 and out_ready=0, and outputs are stable while stalled.
- Reset mid-flight: issue 4 operands, assert rst on the 3rd cycle → out_valid=0 from the next edge and none of the 4 results ever appears. A new operand issued after reset returns normally at LAT.
- Illegal mode: mode 101 with 0x5A5A by 3 → out_data=0x5A5A, out_illegal=1. The following legal LSL 0x0001 by 3 → 0x0008, out_illegal=0.

Source files
------------

// File: rtl/pipelined_universal_shifter.sv
// Pipelined universal shifter: LSL/LSR/ASR/ROL/ROR with one registered mux level per
// shift-amount bit, an input register, a result register and a global valid/ready stall.
module pipelined_universal_shifter #(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shift,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_illegal
);

  localparam int unsigned LG = $clog2(WIDTH);
  localparam int unsigned NS = LG + 1;

  localparam logic [2:0] MODE_LSL = 3'd0;
  localparam logic [2:0] MODE_LSR = 3'd1;
  localparam logic [2:0] MODE_ASR = 3'd2;
  localparam logic [2:0] MODE_ROL = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;

  // Index 0 is the input register; index k+1 holds the value after the 2^k mux level.
  logic [NS-1:0]    vld_q,  vld_d;
  logic [NS-1:0]    sat_q,  sat_d;
  logic [NS-1:0]    sign_q, sign_d;
  logic [NS-1:0]    ill_q,  ill_d;
  logic [WIDTH-1:0] data_q [NS];
  logic [WIDTH-1:0] data_d [NS];
  logic [2:0]       mode_q [NS];
  logic [2:0]       mode_d [NS];
  logic [LG-1:0]    amt_q  [LG];
  logic [LG-1:0]    amt_d  [LG];

  logic             out_valid_q,   out_valid_d;
  logic [WIDTH-1:0] out_data_q,    out_data_d;
  logic             out_zero_q,    out_zero_d;
  logic             out_illegal_q, out_illegal_d;

  logic             adv_c;
  logic             in_ill_c;
  logic             in_rot_c;
  logic [WIDTH-1:0] res_c;

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input logic [2:0]       m,
                                                input int unsigned      sh);
    logic [WIDTH-1:0] r;
    r = d;
    case (m)
      MODE_LSL: r = d << sh;
      MODE_LSR: r = d >> sh;
      MODE_ASR: r = WIDTH'($signed(d) >>> sh);
      MODE_ROL: r = (d << sh) | (d >> (WIDTH - sh));
      MODE_ROR: r = (d >> sh) | (d << (WIDTH - sh));
      default:  r = d;
    endcase
    return r;
  endfunction

  assign adv_c    = !out_valid_q || out_ready;
  assign in_ready = adv_c;
  assign in_ill_c = in_mode > MODE_ROR;
  assign in_rot_c = (in_mode == MODE_ROL) || (in_mode == MODE_ROR);

  // Saturated logical shifts give zero, saturated ASR gives sign fill.
  always_comb begin
    res_c = data_q[LG];
    if (sat_q[LG]) begin
      res_c = (mode_q[LG] == MODE_ASR) ? {WIDTH{sign_q[LG]}} : '0;
    end
  end

  always_comb begin
    vld_d         = vld_q;
    sat_d         = sat_q;
    sign_d        = sign_q;
    ill_d         = ill_q;
    data_d        = data_q;
    mode_d        = mode_q;
    amt_d         = amt_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_zero_d    = out_zero_q;
    out_illegal_d = out_illegal_q;

    if (adv_c) begin
      vld_d[0]  = in_valid;
      data_d[0] = in_data;
      mode_d[0] = in_mode;
      ill_d[0]  = in_ill_c;
      sign_d[0] = in_data[WIDTH-1];
      sat_d[0]  = !in_ill_c && !in_rot_c && in_shift[LG];
      // Illegal modes travel with a zero amount so the stages pass the operand through.
      amt_d[0]  = in_ill_c ? '0 : in_shift[LG-1:0];

      for (int k = 0; k < int'(LG); k++) begin
        vld_d[k+1]  = vld_q[k];
        sat_d[k+1]  = sat_q[k];
        sign_d[k+1] = sign_q[k];
        ill_d[k+1]  = ill_q[k];
        mode_d[k+1] = mode_q[k];
        data_d[k+1] = amt_q[k][k] ? shift_by(data_q[k], mode_q[k], 32'd1 << k) : data_q[k];
        if (k + 1 < int'(LG)) begin
          amt_d[k+1] = amt_q[k];
        end
      end

      out_valid_d = vld_q[LG];
      if (vld_q[LG]) begin
        out_data_d    = res_c;
        out_zero_d    = (res_c == '0);
        out_illegal_d = ill_q[LG];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q         <= '0;
      sat_q         <= '0;
      sign_q        <= '0;
      ill_q         <= '0;
      for (int i = 0; i < int'(NS); i++) begin
        data_q[i] <= '0;
        mode_q[i] <= '0;
      end
      for (int i = 0; i < int'(LG); i++) begin
        amt_q[i] <= '0;
      end
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_zero_q    <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      vld_q         <= vld_d;
      sat_q         <= sat_d;
      sign_q        <= sign_d;
      ill_q         <= ill_d;
      data_q        <= data_d;
      mode_q        <= mode_d;
      amt_q         <= amt_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_zero_q    <= out_zero_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_zero    = out_zero_q;
  assign out_illegal = out_illegal_q;

endmodule
